// File: rtl/mac_conventional_sequencer.sv
// Job sequencer for a two-stage conventional MAC (multiply reg -> accumulator reg).
// Streams (w, a) pairs into the MAC, waits out its latency and returns the sum.
module mac_conventional_sequencer #(
  parameter int W_WIDTH    = 8,
  parameter int A_WIDTH    = 8,
  parameter int PLUS_WIDTH = 4,
  // LEN_WIDTH must not exceed PLUS_WIDTH, otherwise the accumulator can overflow.
  parameter int LEN_WIDTH  = 4,
  localparam int Z_WIDTH   = W_WIDTH + A_WIDTH + PLUS_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W_WIDTH-1:0]   in_w,
  input  logic [A_WIDTH-1:0]   in_a,
  output logic [W_WIDTH-1:0]   mac_w,
  output logic [A_WIDTH-1:0]   mac_a,
  output logic                 mac_accu_rst,
  input  logic [Z_WIDTH-1:0]   mac_z,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [Z_WIDTH-1:0]   res_data,
  output logic [2:0]           state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; a producer holds valid and its data stable until that edge.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FEED    = 3'd1,
    DRAIN   = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [LEN_WIDTH-1:0] cnt;
  logic [LEN_WIDTH-1:0] len_q;
  logic                 accept;

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= len;
            cnt   <= '0;
          end
        end
        // cnt wraps after a full-length job, harmless because FEED is left on that edge.
        FEED: begin
          if (accept) cnt <= cnt + LEN_WIDTH'(1);
        end
        CAPTURE: begin
          res_data  <= mac_z;
          res_valid <= 1'b1;
        end
        DONE: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state   = state;
    busy         = (state != IDLE);
    in_ready     = 1'b0;
    accept       = 1'b0;
    mac_w        = '0;
    mac_a        = '0;
    mac_accu_rst = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = FEED;
      end
      FEED: begin
        in_ready = 1'b1;
        accept   = in_valid;
        // Clearing the accumulator while the first product enters the multiply register.
        mac_accu_rst = (cnt == '0);
        if (accept) begin
          mac_w = in_w;
          mac_a = in_a;
          if (cnt == len_q) next_state = DRAIN;
        end
      end
      DRAIN:   next_state = CAPTURE;
      CAPTURE: next_state = DONE;
      DONE: begin
        if (res_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_conventional_sequencer.sv
// Randomized self-checking bench for mac_conventional_sequencer with a behavioural
// two-stage MAC attached and a plain-arithmetic dot-product reference.
module tb_mac_conventional_sequencer;

  localparam int W_WIDTH    = 8;
  localparam int A_WIDTH    = 8;
  localparam int PLUS_WIDTH = 4;
  localparam int LEN_WIDTH  = 4;
  localparam int Z_WIDTH    = W_WIDTH + A_WIDTH + PLUS_WIDTH;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [LEN_WIDTH-1:0] len;
  logic                 busy;
  logic                 in_valid;
  logic                 in_ready;
  logic [W_WIDTH-1:0]   in_w;
  logic [A_WIDTH-1:0]   in_a;
  logic [W_WIDTH-1:0]   mac_w;
  logic [A_WIDTH-1:0]   mac_a;
  logic                 mac_accu_rst;
  logic [Z_WIDTH-1:0]   mac_z;
  logic                 res_valid;
  logic                 res_ready;
  logic [Z_WIDTH-1:0]   res_data;
  logic [2:0]           state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  int job_w[16];
  int job_a[16];
  logic [Z_WIDTH-1:0] exp_q[$];
  logic [Z_WIDTH-1:0] exp_res;

  mac_conventional_sequencer #(
    .W_WIDTH(W_WIDTH), .A_WIDTH(A_WIDTH), .PLUS_WIDTH(PLUS_WIDTH), .LEN_WIDTH(LEN_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w), .in_a(in_a),
    .mac_w(mac_w), .mac_a(mac_a), .mac_accu_rst(mac_accu_rst), .mac_z(mac_z),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MAC: product register then accumulator; never reset by rst.
  int prod_q = 0;
  int acc_q  = 12345;
  always @(posedge clk) begin
    prod_q <= int'($signed(mac_w)) * int'(mac_a);
    acc_q  <= mac_accu_rst ? 0 : acc_q + prod_q;
  end
  assign mac_z = acc_q[Z_WIDTH-1:0];

  // Drives one job from IDLE up to the cycle where res_valid must first be seen.
  task automatic drive_job(input int n, input int gap, input bit rnd_gap);
    int sum, idx, bub, waits;
    bit v;
    logic [W_WIDTH-1:0] ew;
    logic [A_WIDTH-1:0] ea;
    sum = 0;
    for (int i = 0; i < n; i++) sum += job_w[i] * job_a[i];
    exp_q.push_back(Z_WIDTH'(sum));
    @(negedge clk);
    start = 1'b1;
    len   = LEN_WIDTH'(n - 1);
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_after_start: got %b want 1", busy);
    end
    idx = 0; waits = 0;
    bub = rnd_gap ? int'($urandom_range(0, 2)) : 0;
    while (idx < n && waits < 300) begin
      v = (bub == 0);
      in_valid = v;
      in_w = v ? W_WIDTH'(job_w[idx]) : W_WIDTH'($urandom);
      in_a = v ? A_WIDTH'(job_a[idx]) : A_WIDTH'($urandom);
      ew = v ? W_WIDTH'(job_w[idx]) : '0;
      ea = v ? A_WIDTH'(job_a[idx]) : '0;
      #1;
      n_tests++;
      if (in_ready !== 1'b1 || mac_w !== ew || mac_a !== ea || mac_accu_rst !== (idx == 0)) begin
        n_fail++;
        $display("FAIL feed[%0d]: rdy=%b w=%h a=%h arst=%b want rdy=1 w=%h a=%h arst=%b",
                 idx, in_ready, mac_w, mac_a, mac_accu_rst, ew, ea, (idx == 0));
      end
      @(negedge clk);
      waits++;
      if (v) begin
        idx++;
        bub = rnd_gap ? int'($urandom_range(0, 2)) : gap;
      end else begin
        bub--;
      end
    end
    n_tests++;
    if (waits >= 300) begin
      n_fail++; $display("FAIL feed_timeout: accepted %0d want %0d", idx, n);
    end
    // First cycle after the last accept: extra offered pair must be refused.
    in_valid = 1'b1;
    in_w = W_WIDTH'($urandom);
    in_a = A_WIDTH'($urandom);
    #1;
    n_tests++;
    if (in_ready !== 1'b0 || mac_w !== '0 || mac_a !== '0 || mac_accu_rst !== 1'b0 ||
        res_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL drain: rdy=%b w=%h a=%h arst=%b rv=%b busy=%b want 0 0 0 0 0 1",
               in_ready, mac_w, mac_a, mac_accu_rst, res_valid, busy);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (res_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL capture: rv=%b rdy=%b busy=%b want 0 0 1", res_valid, in_ready, busy);
    end
    @(negedge clk);
    exp_res = exp_q.pop_front();
    n_tests++;
    if (res_valid !== 1'b1 || res_data !== exp_res) begin
      n_fail++;
      $display("FAIL result: rv=%b data=%h want rv=1 data=%h", res_valid, res_data, exp_res);
    end
  endtask

  // Holds res_ready low for `hold` cycles, optionally poking start, then handshakes.
  task automatic take_result(input int hold, input bit poke);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_tests++;
      if (res_valid !== 1'b1 || res_data !== exp_res || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold[%0d]: rv=%b data=%h busy=%b want 1 %h 1",
                 h, res_valid, res_data, busy, exp_res);
      end
      start = poke;
    end
    res_ready = 1'b1;
    start = poke;
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    n_tests++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL handshake: rv=%b busy=%b want 0 0", res_valid, busy);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL idle_after: busy=%b rdy=%b want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_w = '0; in_a = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || mac_w !== '0 || mac_a !== '0 ||
        mac_accu_rst !== 1'b0 || res_valid !== 1'b0 || res_data !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b rdy=%b w=%h a=%h arst=%b rv=%b data=%h want all 0",
               busy, in_ready, mac_w, mac_a, mac_accu_rst, res_valid, res_data);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    job_w[0] = 3; job_a[0] = 5;
    drive_job(1, 0, 1'b0);
    n_tests++;
    if (res_data !== 20'd15) begin
      n_fail++; $display("FAIL single_15: got %h want %h", res_data, 20'd15);
    end
    take_result(0, 1'b0);
  endtask

  task automatic test_extremes();
    for (int i = 0; i < 16; i++) begin job_w[i] = -128; job_a[i] = 255; end
    drive_job(4, 0, 1'b0);
    n_tests++;
    if (res_data !== 20'hE0200) begin
      n_fail++; $display("FAIL four_neg: got %h want %h", res_data, 20'hE0200);
    end
    take_result(1, 1'b0);
    drive_job(16, 0, 1'b0);
    n_tests++;
    if (res_data !== 20'h80800) begin
      n_fail++; $display("FAIL worst_case: got %h want %h", res_data, 20'h80800);
    end
    take_result(0, 1'b0);
  endtask

  task automatic test_bubbles_and_hold();
    job_w[0] = 2;  job_a[0] = 10;
    job_w[1] = -1; job_a[1] = 4;
    job_w[2] = 7;  job_a[2] = 1;
    drive_job(3, 2, 1'b0);
    n_tests++;
    if (res_data !== 20'd23) begin
      n_fail++; $display("FAIL bubbles_23: got %h want %h", res_data, 20'd23);
    end
    take_result(5, 1'b1);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    start = 1'b1; len = 4'd3;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_w = 8'h11; in_a = 8'h22;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || mac_w !== '0 || mac_a !== '0 ||
        mac_accu_rst !== 1'b0 || res_valid !== 1'b0 || res_data !== '0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b rdy=%b w=%h a=%h arst=%b rv=%b data=%h want all 0",
               busy, in_ready, mac_w, mac_a, mac_accu_rst, res_valid, res_data);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    job_w[0] = -1; job_a[0] = 200;
    drive_job(1, 0, 1'b0);
    n_tests++;
    if (res_data !== 20'hFFF38) begin
      n_fail++; $display("FAIL after_reset: got %h want %h", res_data, 20'hFFF38);
    end
    take_result(0, 1'b0);
  endtask

  task automatic test_random_jobs();
    int n;
    for (int j = 0; j < 12; j++) begin
      n = int'($urandom_range(1, 16));
      for (int i = 0; i < n; i++) begin
        job_w[i] = int'($urandom_range(0, 255)) - 128;
        job_a[i] = int'($urandom_range(0, 255));
      end
      drive_job(n, 0, 1'b1);
      take_result(int'($urandom_range(0, 3)), 1'(($urandom_range(0, 1))));
    end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 3; j++) begin
      job_w[0] = j + 1;  job_a[0] = 100;
      job_w[1] = -j - 2; job_a[1] = 7;
      drive_job(2, 0, 1'b0);
      take_result(0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_bubbles_and_hold();
    test_mid_reset();
    test_random_jobs();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
